// File: rtl/olink_rx_framer_pkg.sv
// Shared definitions for the olink receive framer: 8b/10b control characters,
// lane and spy FSM state encodings, and the legal word K-flag test.
package olink_rx_framer_pkg;

  localparam logic [7:0]  CommaChar = 8'hBC;
  localparam logic [7:0]  IdleChar  = 8'hF7;
  localparam logic [7:0]  PadChar   = 8'h1C;
  localparam logic [31:0] PadWord   = {4{PadChar}};

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    StSpyIdle    = 2'd0,
    StSpyWait    = 2'd1,
    StSpyCapture = 2'd2
  } spy_state_e;

  // A 32-bit word may carry no K chars, a comma in its lowest byte, or be all-K.
  function automatic logic word_k_ok(input logic [3:0] k);
    return (k == 4'h0) || (k == 4'h1) || (k == 4'hF);
  endfunction

endpackage

// File: rtl/olink_lane_framer.sv
// One receive lane: pairs 16-bit half-words into 32-bit words, hunts for and
// locks onto comma phase, and counts bad half-words.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   rx_d_i, rx_k_i, rx_nit_i, rx_aligned_i GTX half-word and status
//   cnt_clear_i                            clears err_count_o
//   comma_o                                current half-word is a good comma
//   out_d_o, out_k_o, out_v_o              assembled word, K flags, strobe
//   locked_o                               lane is in the locked state
//   err_count_o                            saturating bad half-word count
module olink_lane_framer
  import olink_rx_framer_pkg::*;
#(
  parameter int unsigned LockCount  = 4,
  parameter int unsigned UnlockErrs = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] rx_d_i,
  input  logic [1:0]  rx_k_i,
  input  logic [1:0]  rx_nit_i,
  input  logic        rx_aligned_i,
  input  logic        cnt_clear_i,
  output logic        comma_o,
  output logic [31:0] out_d_o,
  output logic [3:0]  out_k_o,
  output logic        out_v_o,
  output logic        locked_o,
  output logic [31:0] err_count_o
);

  localparam logic [7:0] LockLim   = 8'(LockCount);
  localparam logic [8:0] UnlockLim = 9'(UnlockErrs);

  lane_state_e state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [8:0]  win_err_q, win_err_d, win_err_sum;
  logic [15:0] prev_d_q;
  logic [1:0]  prev_k_q;
  logic        prev_good_q;
  logic [31:0] out_d_q, out_d_d;
  logic [3:0]  out_k_q, out_k_d;
  logic        out_v_q, out_v_d;
  logic        locked_q;
  logic [31:0] err_count_q, err_count_d;

  logic       good, comma, misphase, err_now;
  logic [3:0] word_k;

  assign good     = (rx_nit_i == 2'b00) && rx_aligned_i;
  assign comma    = good && (rx_k_i == 2'b01) && (rx_d_i[7:0] == CommaChar);
  // Commas (or a K in the upper byte) belong in the low half; seen in the high half they
  // mean the pairing is wrong.
  assign misphase = phase_q && (comma || (rx_k_i == 2'b10));
  assign err_now  = !good || misphase;
  assign word_k   = {rx_k_i, prev_k_q};

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    win_err_sum = '0;
    phase_d     = comma ? 1'b1 : ~phase_q;
    unique case (state_q)
      StHunt: begin
        if (comma) begin
          state_d    = StVerify;
          lock_cnt_d = 8'd1;
        end
      end
      StVerify: begin
        if (err_now) begin
          state_d    = StHunt;
          lock_cnt_d = '0;
        end else if (comma) begin
          if (lock_cnt_q + 8'd1 >= LockLim) begin
            state_d   = StLocked;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end
      end
      StLocked: begin
        // The error window restarts every 256 half-words.
        win_cnt_d   = win_cnt_q + 8'd1;
        win_err_sum = ((win_cnt_q == 8'hFF) ? 9'd0 : win_err_q) + {8'd0, err_now};
        win_err_d   = win_err_sum;
        if (win_err_sum >= UnlockLim) begin
          state_d    = StHunt;
          lock_cnt_d = '0;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    out_v_d = (state_q == StLocked) && phase_q;
    out_d_d = out_d_q;
    out_k_d = out_k_q;
    if (out_v_d) begin
      if (!good || !prev_good_q || !word_k_ok(word_k)) begin
        out_d_d = PadWord;
        out_k_d = 4'hF;
      end else begin
        out_d_d = {rx_d_i, prev_d_q};
        out_k_d = word_k;
      end
    end
    err_count_d = err_count_q;
    if (cnt_clear_i) begin
      err_count_d = '0;
    end else if (!good && (err_count_q != 32'hFFFF_FFFF)) begin
      err_count_d = err_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHunt;
      phase_q     <= 1'b0;
      lock_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      prev_d_q    <= '0;
      prev_k_q    <= '0;
      prev_good_q <= 1'b0;
      out_d_q     <= '0;
      out_k_q     <= '0;
      out_v_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lock_cnt_q  <= lock_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      prev_d_q    <= rx_d_i;
      prev_k_q    <= rx_k_i;
      prev_good_q <= good;
      out_d_q     <= out_d_d;
      out_k_q     <= out_k_d;
      out_v_q     <= out_v_d;
      locked_q    <= (state_d == StLocked);
      err_count_q <= err_count_d;
    end
  end

  assign comma_o     = comma;
  assign out_d_o     = out_d_q;
  assign out_k_o     = out_k_q;
  assign out_v_o     = out_v_q;
  assign locked_o    = locked_q;
  assign err_count_o = err_count_q;

endmodule

// File: rtl/olink_rx_framer.sv
// Multi-lane GTX receive framer with a single-lane spy buffer.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   rx_d, rx_k, rx_nit, rx_aligned   per-lane GTX receive data and status
//   out_d, out_k, out_v              per-lane assembled words and strobes
//   locked, err_count                per-lane lock status and error counters
//   cnt_clear                        clears all error counters
//   spy_arm, spy_lane, spy_trig_comma  spy capture control
//   spy_addr, spy_data, spy_done     spy readback (1-cycle latency) and full flag
module olink_rx_framer
  import olink_rx_framer_pkg::*;
#(
  parameter int unsigned N_LANES     = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned UNLOCK_ERRS = 8,
  parameter int unsigned SPY_DEPTH   = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [16*N_LANES-1:0]        rx_d,
  input  logic [2*N_LANES-1:0]         rx_k,
  input  logic [2*N_LANES-1:0]         rx_nit,
  input  logic [N_LANES-1:0]           rx_aligned,
  output logic [32*N_LANES-1:0]        out_d,
  output logic [4*N_LANES-1:0]         out_k,
  output logic [N_LANES-1:0]           out_v,
  output logic [N_LANES-1:0]           locked,
  output logic [32*N_LANES-1:0]        err_count,
  input  logic                         cnt_clear,
  input  logic                         spy_arm,
  input  logic [1:0]                   spy_lane,
  input  logic                         spy_trig_comma,
  input  logic [$clog2(SPY_DEPTH)-1:0] spy_addr,
  output logic [19:0]                  spy_data,
  output logic                         spy_done
);

  localparam int unsigned      Aw      = $clog2(SPY_DEPTH);
  localparam logic [Aw-1:0]    LastPtr = Aw'(SPY_DEPTH - 1);
  localparam logic [2:0]       NLanesW = 3'(N_LANES);

  logic [N_LANES-1:0] lane_comma;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    olink_lane_framer #(
      .LockCount (LOCK_COUNT),
      .UnlockErrs(UNLOCK_ERRS)
    ) u_lane (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .rx_d_i      (rx_d[16*i +: 16]),
      .rx_k_i      (rx_k[2*i +: 2]),
      .rx_nit_i    (rx_nit[2*i +: 2]),
      .rx_aligned_i(rx_aligned[i]),
      .cnt_clear_i (cnt_clear),
      .comma_o     (lane_comma[i]),
      .out_d_o     (out_d[32*i +: 32]),
      .out_k_o     (out_k[4*i +: 4]),
      .out_v_o     (out_v[i]),
      .locked_o    (locked[i]),
      .err_count_o (err_count[32*i +: 32])
    );
  end

  spy_state_e    spy_state_q, spy_state_d;
  logic [Aw-1:0] spy_ptr_q, spy_ptr_d;
  logic          spy_done_q, spy_done_d;
  logic          spy_wr;
  logic [1:0]    spy_sel;
  logic [19:0]   spy_wdata;
  logic          spy_comma;
  logic [19:0]   spy_mem_q [SPY_DEPTH];
  logic [19:0]   spy_data_q;

  // Out-of-range lane selects fall back to lane 0.
  always_comb begin
    spy_sel = 2'd0;
    if ({1'b0, spy_lane} < NLanesW) spy_sel = spy_lane;
  end

  always_comb begin
    spy_wdata = '0;
    spy_comma = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (spy_sel == 2'(i)) begin
        spy_wdata = {rx_nit[2*i +: 2], rx_k[2*i +: 2], rx_d[16*i +: 16]};
        spy_comma = lane_comma[i];
      end
    end
  end

  always_comb begin
    spy_state_d = spy_state_q;
    spy_ptr_d   = spy_ptr_q;
    spy_done_d  = spy_done_q;
    spy_wr      = 1'b0;
    if (spy_arm) begin
      spy_ptr_d   = '0;
      spy_done_d  = 1'b0;
      spy_state_d = spy_trig_comma ? StSpyWait : StSpyCapture;
    end else begin
      unique case (spy_state_q)
        StSpyWait: begin
          // The triggering comma itself becomes entry 0.
          if (spy_comma) begin
            spy_wr      = 1'b1;
            spy_ptr_d   = spy_ptr_q + 1'b1;
            spy_state_d = StSpyCapture;
          end
        end
        StSpyCapture: begin
          spy_wr = 1'b1;
          if (spy_ptr_q == LastPtr) begin
            spy_done_d  = 1'b1;
            spy_state_d = StSpyIdle;
          end else begin
            spy_ptr_d = spy_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spy_state_q <= StSpyIdle;
      spy_ptr_q   <= '0;
      spy_done_q  <= 1'b0;
    end else begin
      spy_state_q <= spy_state_d;
      spy_ptr_q   <= spy_ptr_d;
      spy_done_q  <= spy_done_d;
    end
  end

  // Capture memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (spy_wr) spy_mem_q[spy_ptr_q] <= spy_wdata;
    spy_data_q <= spy_mem_q[spy_addr];
  end

  assign spy_data = spy_data_q;
  assign spy_done = spy_done_q;

endmodule

// File: tb/tb_olink_rx_framer.sv
module tb_olink_rx_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rx_d;
  logic [3:0]  rx_k;
  logic [3:0]  rx_nit;
  logic [1:0]  rx_aligned;
  logic [63:0] out_d;
  logic [7:0]  out_k;
  logic [1:0]  out_v;
  logic [1:0]  locked;
  logic [63:0] err_count;
  logic        cnt_clear;
  logic        spy_arm;
  logic [1:0]  spy_lane;
  logic        spy_trig_comma;
  logic [5:0]  spy_addr;
  logic [19:0] spy_data;
  logic        spy_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  olink_rx_framer #(
    .N_LANES    (2),
    .LOCK_COUNT (4),
    .UNLOCK_ERRS(8),
    .SPY_DEPTH  (64)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_d          (rx_d),
    .rx_k          (rx_k),
    .rx_nit        (rx_nit),
    .rx_aligned    (rx_aligned),
    .out_d         (out_d),
    .out_k         (out_k),
    .out_v         (out_v),
    .locked        (locked),
    .err_count     (err_count),
    .cnt_clear     (cnt_clear),
    .spy_arm       (spy_arm),
    .spy_lane      (spy_lane),
    .spy_trig_comma(spy_trig_comma),
    .spy_addr      (spy_addr),
    .spy_data      (spy_data),
    .spy_done      (spy_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int ln, input logic [15:0] d, input logic [1:0] k,
                     input logic [1:0] nit);
    rx_d[16*ln +: 16] = d;
    rx_k[2*ln +: 2]   = k;
    rx_nit[2*ln +: 2] = nit;
  endtask

  initial begin
    reset_n        = 1'b0;
    rx_d           = '0;
    rx_k           = '0;
    rx_nit         = '0;
    rx_aligned     = 2'b11;
    cnt_clear      = 1'b0;
    spy_arm        = 1'b0;
    spy_lane       = 2'd0;
    spy_trig_comma = 1'b0;
    spy_addr       = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_out_v", 32'(out_v), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_out_d0", out_d[31:0], 32'h0);
    chk("rst_out_k", 32'(out_k), 32'h0);
    chk("rst_err0", err_count[31:0], 32'h0);
    chk("rst_spy_done", 32'(spy_done), 32'h0);
    reset_n = 1'b1;
    tick();

    // Lock lane 0 with four correctly spaced commas
    for (int i = 0; i < 4; i++) begin
      drv(0, 16'h4ABC, 2'b01, 2'b00);
      tick();
      if (i == 2) chk("lock_after_3", 32'(locked[0]), 32'h0);
      if (i == 3) chk("lock_after_4", 32'(locked[0]), 32'h1);
      drv(0, 16'h5678, 2'b00, 2'b00);
      tick();
      if (i == 1) chk("verify_no_v", 32'(out_v[0]), 32'h0);
      if (i == 3) begin
        chk("comma_word_v", 32'(out_v[0]), 32'h1);
        chk("comma_word_d", out_d[31:0], 32'h5678_4ABC);
        chk("comma_word_k", 32'(out_k[3:0]), 32'h1);
      end
    end
    for (int j = 0; j < 3; j++) begin
      drv(0, 16'h1234, 2'b00, 2'b00);
      tick();
      chk("data_low_v", 32'(out_v[0]), 32'h0);
      drv(0, 16'h5678, 2'b00, 2'b00);
      tick();
      chk("data_v", 32'(out_v[0]), 32'h1);
      chk("data_d", out_d[31:0], 32'h5678_1234);
      chk("data_k", 32'(out_k[3:0]), 32'h0);
    end
    chk("lane1_unlocked", 32'(locked[1]), 32'h0);

    // Eight bad half-words drop lock
    for (int b = 1; b <= 8; b++) begin
      drv(0, (b % 2 == 1) ? 16'h1234 : 16'h5678, 2'b00, 2'b01);
      tick();
      if (b == 2) begin
        chk("pad_v", 32'(out_v[0]), 32'h1);
        chk("pad_d", out_d[31:0], 32'h1C1C_1C1C);
        chk("pad_k", 32'(out_k[3:0]), 32'hF);
      end
      if (b == 7) chk("lock_after_7_err", 32'(locked[0]), 32'h1);
    end
    chk("unlock_after_8_err", 32'(locked[0]), 32'h0);
    chk("err_count_8", err_count[31:0], 32'd8);

    // Saturation and clear-wins-over-error
    drv(0, 16'h0000, 2'b00, 2'b00);
    force dut.g_lane[0].u_lane.err_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.g_lane[0].u_lane.err_count_q;
    drv(0, 16'h0000, 2'b00, 2'b01);
    tick();
    chk("err_saturate", err_count[31:0], 32'hFFFF_FFFF);
    cnt_clear = 1'b1;
    tick();
    chk("err_clear_with_err", err_count[31:0], 32'h0);
    cnt_clear = 1'b0;
    drv(0, 16'h0000, 2'b00, 2'b00);
    tick();
    chk("err_stays_clear", err_count[31:0], 32'h0);
    chk("err_lane1_zero", err_count[63:32], 32'h0);

    // Comma on the high half during verify returns to hunt
    drv(0, 16'h4ABC, 2'b01, 2'b00);
    tick();
    tick();
    drv(0, 16'h0000, 2'b00, 2'b00);
    tick();
    for (int c = 0; c < 3; c++) begin
      drv(0, 16'h4ABC, 2'b01, 2'b00);
      tick();
      drv(0, 16'h5678, 2'b00, 2'b00);
      tick();
    end
    chk("misphase_rehunt", 32'(locked[0]), 32'h0);
    drv(0, 16'h4ABC, 2'b01, 2'b00);
    tick();
    chk("misphase_relock", 32'(locked[0]), 32'h1);

    // Asynchronous reset while locked
    drv(0, 16'h5678, 2'b00, 2'b00);
    tick();
    chk("pre_reset_v", 32'(out_v[0]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_v", 32'(out_v[0]), 32'h0);
    chk("async_rst_locked", 32'(locked[0]), 32'h0);
    chk("async_rst_d", out_d[31:0], 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(0, 16'h4ABC, 2'b01, 2'b00);
      tick();
      if (i == 2) chk("relock_after_3", 32'(locked[0]), 32'h0);
      if (i == 3) chk("relock_after_4", 32'(locked[0]), 32'h1);
      drv(0, 16'h5678, 2'b00, 2'b00);
      tick();
    end

    // Spy: comma-triggered capture on lane 1
    drv(0, 16'h0000, 2'b00, 2'b00);
    drv(1, 16'h0000, 2'b00, 2'b00);
    spy_lane       = 2'd1;
    spy_trig_comma = 1'b1;
    spy_arm        = 1'b1;
    tick();
    spy_arm = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      drv(1, 16'h0100 + 16'(c), 2'b00, 2'b00);
      if (c == 5) drv(0, 16'h4ABC, 2'b01, 2'b00);
      else drv(0, 16'h0000, 2'b00, 2'b00);
      tick();
    end
    drv(0, 16'h0000, 2'b00, 2'b00);
    drv(1, 16'h77BC, 2'b01, 2'b00);
    tick();
    chk("spy_not_done_at_trig", 32'(spy_done), 32'h0);
    for (int j = 1; j <= 63; j++) begin
      drv(1, 16'h2000 + 16'(j), 2'b00, 2'b00);
      tick();
      if (j == 62) chk("spy_not_done_62", 32'(spy_done), 32'h0);
    end
    chk("spy_done_64", 32'(spy_done), 32'h1);
    drv(1, 16'hDEAD, 2'b00, 2'b00);
    tick();
    tick();
    spy_addr = 6'd0;
    tick();
    chk("spy_entry0", 32'(spy_data), 32'h0_177BC);
    spy_addr = 6'd1;
    tick();
    chk("spy_entry1", 32'(spy_data), 32'h0_02001);
    spy_addr = 6'd63;
    tick();
    chk("spy_entry63", 32'(spy_data), 32'h0_0203F);

    // Spy: immediate capture, re-arm clears done
    spy_trig_comma = 1'b0;
    spy_arm        = 1'b1;
    tick();
    spy_arm = 1'b0;
    chk("spy_rearm_clears", 32'(spy_done), 32'h0);
    for (int i = 0; i < 64; i++) begin
      drv(1, 16'h3000 + 16'(i), 2'b00, 2'b00);
      tick();
      if (i == 62) chk("spy_imm_not_done", 32'(spy_done), 32'h0);
    end
    chk("spy_imm_done", 32'(spy_done), 32'h1);
    spy_addr = 6'd0;
    tick();
    chk("spy_imm_entry0", 32'(spy_data), 32'h0_03000);
    spy_addr = 6'd5;
    tick();
    chk("spy_imm_entry5", 32'(spy_data), 32'h0_03005);

    // Spy: out-of-range lane select captures lane 0
    spy_lane = 2'd3;
    spy_arm  = 1'b1;
    tick();
    spy_arm = 1'b0;
    drv(0, 16'h5A5A, 2'b00, 2'b00);
    drv(1, 16'h0FFF, 2'b00, 2'b00);
    tick();
    spy_addr = 6'd0;
    tick();
    chk("spy_lane_oor", 32'(spy_data), 32'h0_05A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
